// File: rtl/falling_edge_pulse_gen.sv
// Trigger strobes become active-low pulses on dout. Each pulse has a programmable low width,
// followed by a minimum high gap. Strobes that arrive during a pulse are queued and replayed.
module falling_edge_pulse_gen #(
  parameter int unsigned CNT_BITS  = 8,
  parameter int unsigned PEND_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trig,
  input  logic [CNT_BITS-1:0]  low_len,
  input  logic [CNT_BITS-1:0]  gap_len,
  input  logic                 ovf_clr,
  output logic                 dout,
  output logic                 done,
  output logic                 busy,
  output logic [PEND_BITS-1:0] pending,
  output logic                 ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [PEND_BITS-1:0] pend_q, pend_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  logic                 req_avail;
  logic                 start;
  logic [CNT_BITS-1:0]  low_load;
  logic [CNT_BITS-1:0]  gap_load;

  always_comb begin
    low_load  = (low_len == '0) ? '0 : low_len - 1'b1;
    gap_load  = (gap_len == '0) ? '0 : gap_len - 1'b1;
    req_avail = trig || (pend_q != '0);
    start     = req_avail && ((state_q == IDLE) || (state_q == GAP && cnt_q == '0));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOW;
          cnt_d   = low_load;
        end
      end
      LOW: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = gap_load;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (start) begin
            state_d = LOW;
            cnt_d   = low_load;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A start with an empty queue consumes trig directly; otherwise the head is dequeued and
  // a concurrent trig takes its place.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (start) begin
      if (pend_q != '0 && !trig) begin
        pend_d = pend_q - 1'b1;
      end
    end else if (trig) begin
      if (pend_q == '1) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    dout    = (state_q != LOW);
    done    = done_q;
    busy    = (state_q != IDLE) || (pend_q != '0);
    pending = pend_q;
    ovf     = ovf_q;
  end

endmodule

// File: tb/tb_falling_edge_pulse_gen.sv
// Directed bench for falling_edge_pulse_gen; expected sequences are hand-derived cycle by cycle.
module tb_falling_edge_pulse_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       trig;
  logic [7:0] low_len;
  logic [7:0] gap_len;
  logic       ovf_clr;
  logic       dout;
  logic       done;
  logic       busy;
  logic [1:0] pending;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Samples taken 1 ns after each active edge, index 0 = right after the trig edge.
  int t2_dout [6]  = '{0, 0, 0, 1, 1, 1};
  int t2_done [6]  = '{0, 0, 0, 1, 0, 0};
  int t2_busy [6]  = '{1, 1, 1, 1, 1, 0};
  int t3_dout [10] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 1};
  int t3_done [10] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
  int t3_pend [10] = '{0, 1, 2, 1, 1, 1, 0, 0, 0, 0};
  int t3_busy [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int t4_dout [9]  = '{0, 1, 0, 1, 0, 1, 0, 1, 1};
  int t4_done [9]  = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
  int t4_pend [9]  = '{0, 1, 1, 2, 1, 1, 0, 0, 0};
  int t4_busy [9]  = '{1, 1, 1, 1, 1, 1, 1, 1, 0};

  falling_edge_pulse_gen #(
    .CNT_BITS  (8),
    .PEND_BITS (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .trig    (trig),
    .low_len (low_len),
    .gap_len (gap_len),
    .ovf_clr (ovf_clr),
    .dout    (dout),
    .done    (done),
    .busy    (busy),
    .pending (pending),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int falls;
  int dones;
  int max_pend;
  logic prev_dout;
  int budget;

  initial begin
    rst = 1'b1; trig = 1'b0; low_len = 8'd3; gap_len = 8'd2; ovf_clr = 1'b0;

    // 1: reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    check_eq("rst dout", 32'(dout), 1);
    check_eq("rst done", 32'(done), 0);
    check_eq("rst busy", 32'(busy), 0);
    check_eq("rst pending", 32'(pending), 0);
    check_eq("rst ovf", 32'(ovf), 0);

    // 2: single pulse, L=3 G=2; low_len change mid-pulse must be ignored
    low_len = 8'd3; gap_len = 8'd2;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    low_len = 8'd7;
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("t2 dout[%0d]", i), 32'(dout), 32'(t2_dout[i]));
      check_eq($sformatf("t2 done[%0d]", i), 32'(done), 32'(t2_done[i]));
      check_eq($sformatf("t2 busy[%0d]", i), 32'(busy), 32'(t2_busy[i]));
      if (i < 5) tick();
    end
    tick();

    // 3: three consecutive trigs, L=2 G=1
    low_len = 8'd2; gap_len = 8'd1;
    for (int i = 0; i < 10; i++) begin
      trig = (i < 3);
      tick();
      check_eq($sformatf("t3 dout[%0d]", i), 32'(dout), 32'(t3_dout[i]));
      check_eq($sformatf("t3 done[%0d]", i), 32'(done), 32'(t3_done[i]));
      check_eq($sformatf("t3 pend[%0d]", i), 32'(pending), 32'(t3_pend[i]));
      check_eq($sformatf("t3 busy[%0d]", i), 32'(busy), 32'(t3_busy[i]));
    end
    trig = 1'b0;
    tick();

    // 4: zero lengths treated as 1, trig held 4 cycles
    low_len = 8'd0; gap_len = 8'd0;
    for (int i = 0; i < 9; i++) begin
      trig = (i < 4);
      tick();
      check_eq($sformatf("t4 dout[%0d]", i), 32'(dout), 32'(t4_dout[i]));
      check_eq($sformatf("t4 done[%0d]", i), 32'(done), 32'(t4_done[i]));
      check_eq($sformatf("t4 pend[%0d]", i), 32'(pending), 32'(t4_pend[i]));
      check_eq($sformatf("t4 busy[%0d]", i), 32'(busy), 32'(t4_busy[i]));
    end
    trig = 1'b0;
    tick();

    // 5: saturation with 2-bit pending, 6 trigs; ovf set wins over a same-cycle clear
    low_len = 8'd4; gap_len = 8'd2;
    falls = 0; dones = 0; max_pend = 0; prev_dout = 1'b1;
    for (int i = 0; i < 6; i++) begin
      trig = 1'b1;
      ovf_clr = (i == 5);
      tick();
      if (prev_dout && !dout) falls++;
      if (done) dones++;
      if (int'(pending) > max_pend) max_pend = int'(pending);
      prev_dout = dout;
    end
    trig = 1'b0; ovf_clr = 1'b0;
    check_eq("t5 ovf set", 32'(ovf), 1);
    check_eq("t5 pending sat", 32'(pending), 3);
    budget = 0;
    while (busy && budget < 200) begin
      tick();
      budget++;
      if (prev_dout && !dout) falls++;
      if (done) dones++;
      if (int'(pending) > max_pend) max_pend = int'(pending);
      prev_dout = dout;
    end
    check_eq("t5 drained in budget", 32'(busy), 0);
    check_eq("t5 max pending", 32'(max_pend), 3);
    check_eq("t5 pulses", 32'(falls), 4);
    check_eq("t5 done strobes", 32'(dones), 4);
    check_eq("t5 ovf sticky", 32'(ovf), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_eq("t5 ovf cleared", 32'(ovf), 0);

    // 6: reset mid-pulse with two requests pending
    low_len = 8'd4; gap_len = 8'd2;
    for (int i = 0; i < 3; i++) begin
      trig = 1'b1;
      tick();
    end
    trig = 1'b0;
    check_eq("t6 pre dout", 32'(dout), 0);
    check_eq("t6 pre pending", 32'(pending), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6 dout", 32'(dout), 1);
    check_eq("t6 pending", 32'(pending), 0);
    check_eq("t6 busy", 32'(busy), 0);
    check_eq("t6 done", 32'(done), 0);
    falls = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!dout) falls++;
    end
    check_eq("t6 no pulses", 32'(falls), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
